reg_dump_reader: RTL and testbench

Register-file readback engine. It sequences reads of a programmable register range out of gen_regs through its two read ports, and streams each register's index and value out over a valid/ready interface. It also accumulates an XOR checksum of the streamed words. It is the read-side counterpart to the ALU-to-register-file writeback path, used by benches and debug logic to dump architectural state after a run.

---
 rtl/reg_dump_reader.sv | 248 ++++++++++++++++++++++++
 tb/tb_reg_dump_reader.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_reader.sv
// ---------------------------------------------------------------------------
// reg_dump_reader
//
// Register-file readback engine. Walks a programmable index range
// [first, last] of gen_regs two registers at a time through its two
// combinational read ports and streams each register as an (index, value)
// word over a valid/ready interface. An XOR checksum of every transferred
// word is kept and is cleared when a dump is accepted.
//
// Ports
//   clk            system clock, all state on rising edge
//   reset          asynchronous, active-high reset
//   start_i        dump request, sampled only while idle
//   first_i        first register index, latched on accepted start
//   last_i         last register index (inclusive), latched on accepted start
//   busy_o         dump in progress
//   done_o         one-cycle pulse on completion or rejection
//   err_o          one-cycle pulse with done_o when first_i > last_i
//   regRAddr1_o    gen_regs read address, port 1
//   regRAddr2_o    gen_regs read address, port 2
//   regRData1_i    gen_regs read data, port 1
//   regRData2_i    gen_regs read data, port 2
//   dump_valid_o   stream word valid
//   dump_ready_i   stream sink ready
//   dump_addr_o    register index of current word
//   dump_data_o    register value of current word
//   dump_last_o    current word is the last index of the range
//   checksum_o     XOR of all words transferred since last accepted start
// ---------------------------------------------------------------------------
module reg_dump_reader #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] first_i,
    input  logic [ADDR_W-1:0] last_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [ADDR_W-1:0] regRAddr1_o,
    output logic [ADDR_W-1:0] regRAddr2_o,
    input  logic [DATA_W-1:0] regRData1_i,
    input  logic [DATA_W-1:0] regRData2_i,
    output logic              dump_valid_o,
    input  logic              dump_ready_i,
    output logic [ADDR_W-1:0] dump_addr_o,
    output logic [DATA_W-1:0] dump_data_o,
    output logic              dump_last_o,
    output logic [DATA_W-1:0] checksum_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SEND0,
        S_SEND1,
        S_FIN
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_ptr, w_ptr_nxt;
    logic [ADDR_W-1:0] r_last, w_last_nxt;

    // Second word of a fetched pair. The first word of the pair lives
    // directly in the registered stream outputs, so it needs no copy.
    logic [ADDR_W-1:0] r_buf1_addr, w_buf1_addr_nxt;
    logic [DATA_W-1:0] r_buf1_data, w_buf1_data_nxt;
    logic              r_buf1_valid, w_buf1_valid_nxt;

    // Registered outputs.
    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;
    logic              r_err, w_err_nxt;
    logic              r_valid, w_valid_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [DATA_W-1:0] r_data, w_data_nxt;
    logic              r_dlast, w_dlast_nxt;
    logic [DATA_W-1:0] r_csum, w_csum_nxt;

    logic              w_handshake;
    logic [ADDR_W-1:0] w_ptr_inc;

    assign w_handshake = r_valid & dump_ready_i;
    // Only used while ptr < last, and last fits in ADDR_W, so no wrap.
    assign w_ptr_inc   = r_ptr + ADDR_W'(1);

    assign busy_o       = r_busy;
    assign done_o       = r_done;
    assign err_o        = r_err;
    assign dump_valid_o = r_valid;
    assign dump_addr_o  = r_addr;
    assign dump_data_o  = r_data;
    assign dump_last_o  = r_dlast;
    assign checksum_o   = r_csum;

    // Read addresses are only meaningful in FETCH; parked at 0 elsewhere.
    always_comb begin
        regRAddr1_o = '0;
        regRAddr2_o = '0;
        if (r_state == S_FETCH) begin
            regRAddr1_o = r_ptr;
            regRAddr2_o = (r_ptr < r_last) ? w_ptr_inc : r_ptr;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves one unassigned, which would infer a latch.
        w_state_nxt      = r_state;
        w_ptr_nxt        = r_ptr;
        w_last_nxt       = r_last;
        w_buf1_addr_nxt  = r_buf1_addr;
        w_buf1_data_nxt  = r_buf1_data;
        w_buf1_valid_nxt = r_buf1_valid;
        w_busy_nxt       = r_busy;
        w_done_nxt       = 1'b0;
        w_err_nxt        = 1'b0;
        w_valid_nxt      = r_valid;
        w_addr_nxt       = r_addr;
        w_data_nxt       = r_data;
        w_dlast_nxt      = r_dlast;
        w_csum_nxt       = r_csum;

        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    if (first_i <= last_i) begin
                        w_ptr_nxt   = first_i;
                        w_last_nxt  = last_i;
                        w_csum_nxt  = '0;
                        w_busy_nxt  = 1'b1;
                        w_state_nxt = S_FETCH;
                    end else begin
                        // Rejected range: report and stay idle.
                        w_done_nxt = 1'b1;
                        w_err_nxt  = 1'b1;
                    end
                end
            end

            S_FETCH: begin
                // Port 1 goes straight to the stream outputs; port 2 is
                // parked in buf1 and is only valid if the range has room.
                w_valid_nxt      = 1'b1;
                w_addr_nxt       = r_ptr;
                w_data_nxt       = regRData1_i;
                w_dlast_nxt      = (r_ptr == r_last);
                w_buf1_addr_nxt  = w_ptr_inc;
                w_buf1_data_nxt  = regRData2_i;
                w_buf1_valid_nxt = (r_ptr < r_last);
                w_state_nxt      = S_SEND0;
            end

            S_SEND0: begin
                if (w_handshake) begin
                    w_csum_nxt = r_csum ^ r_data;
                    if (r_buf1_valid) begin
                        // Valid stays high; swap in the second word.
                        w_addr_nxt       = r_buf1_addr;
                        w_data_nxt       = r_buf1_data;
                        w_dlast_nxt      = (r_buf1_addr == r_last);
                        w_buf1_valid_nxt = 1'b0;
                        w_state_nxt      = S_SEND1;
                    end else if (r_addr == r_last) begin
                        w_valid_nxt = 1'b0;
                        w_dlast_nxt = 1'b0;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_FIN;
                    end else begin
                        w_valid_nxt = 1'b0;
                        w_dlast_nxt = 1'b0;
                        w_ptr_nxt   = w_ptr_inc;
                        w_state_nxt = S_FETCH;
                    end
                end
            end

            S_SEND1: begin
                if (w_handshake) begin
                    w_csum_nxt  = r_csum ^ r_data;
                    w_valid_nxt = 1'b0;
                    w_dlast_nxt = 1'b0;
                    if (r_addr == r_last) begin
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_FIN;
                    end else begin
                        // buf1 index was ptr+1 < last, so ptr+2 <= last.
                        w_ptr_nxt   = r_ptr + ADDR_W'(2);
                        w_state_nxt = S_FETCH;
                    end
                end
            end

            S_FIN: begin
                // done_o is high during this cycle and cleared by default.
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    // NOTE: the datapath registers are reset too, not just control, because
    // the stream outputs and checksum must read 0 straight out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_ptr        <= '0;
            r_last       <= '0;
            r_buf1_addr  <= '0;
            r_buf1_data  <= '0;
            r_buf1_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_valid      <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
            r_dlast      <= 1'b0;
            r_csum       <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_ptr        <= w_ptr_nxt;
            r_last       <= w_last_nxt;
            r_buf1_addr  <= w_buf1_addr_nxt;
            r_buf1_data  <= w_buf1_data_nxt;
            r_buf1_valid <= w_buf1_valid_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_err        <= w_err_nxt;
            r_valid      <= w_valid_nxt;
            r_addr       <= w_addr_nxt;
            r_data       <= w_data_nxt;
            r_dlast      <= w_dlast_nxt;
            r_csum       <= w_csum_nxt;
        end
    end

endmodule

// File: tb/tb_reg_dump_reader.sv
// ---------------------------------------------------------------------------
// tb_reg_dump_reader
//
// Self-checking bench for reg_dump_reader. A small array stands in for
// gen_regs (combinational reads, x0 hard-wired to 0). For each dump the
// expected stream is simply the list of (index, regs[index]) for index in
// first..last, and the expected checksum is the XOR of those values.
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_reg_dump_reader;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              start_i;
    logic [ADDR_W-1:0] first_i;
    logic [ADDR_W-1:0] last_i;
    logic              busy_o;
    logic              done_o;
    logic              err_o;
    logic [ADDR_W-1:0] regRAddr1_o;
    logic [ADDR_W-1:0] regRAddr2_o;
    logic [DATA_W-1:0] regRData1_i;
    logic [DATA_W-1:0] regRData2_i;
    logic              dump_valid_o;
    logic              dump_ready_i;
    logic [ADDR_W-1:0] dump_addr_o;
    logic [DATA_W-1:0] dump_data_o;
    logic              dump_last_o;
    logic [DATA_W-1:0] checksum_o;

    logic [DATA_W-1:0] regs [32];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign regRData1_i = regs[regRAddr1_o];
    assign regRData2_i = regs[regRAddr2_o];

    reg_dump_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start_i),
        .first_i      (first_i),
        .last_i       (last_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .regRAddr1_o  (regRAddr1_o),
        .regRAddr2_o  (regRAddr2_o),
        .regRData1_i  (regRData1_i),
        .regRData2_i  (regRData2_i),
        .dump_valid_o (dump_valid_o),
        .dump_ready_i (dump_ready_i),
        .dump_addr_o  (dump_addr_o),
        .dump_data_o  (dump_data_o),
        .dump_last_o  (dump_last_o),
        .checksum_o   (checksum_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " busy"},   64'(busy_o), 0);
        check({tag, " done"},   64'(done_o), 0);
        check({tag, " err"},    64'(err_o), 0);
        check({tag, " valid"},  64'(dump_valid_o), 0);
        check({tag, " last"},   64'(dump_last_o), 0);
        check({tag, " raddr1"}, 64'(regRAddr1_o), 0);
        check({tag, " raddr2"}, 64'(regRAddr2_o), 0);
        check({tag, " daddr"},  64'(dump_addr_o), 0);
        check({tag, " ddata"},  64'(dump_data_o), 0);
        check({tag, " csum"},   64'(checksum_o), 0);
    endtask

    // ready modes: 0 = always 1, 1 = repeating 1,0,0, 2 = random
    task automatic run_dump(input int f, input int l, input int mode, input bit poke_start);
        int                exp_addr [$];
        logic [DATA_W-1:0] exp_data [$];
        logic [DATA_W-1:0] exp_sum;
        int                n;
        int                cyc;
        int                got;
        bit                done_seen;
        bit                hold;
        bit                rdy;
        logic [ADDR_W-1:0] h_addr;
        logic [DATA_W-1:0] h_data;
        logic              h_last;

        exp_sum = '0;
        for (int i = f; i <= l; i++) begin
            exp_addr.push_back(i);
            exp_data.push_back(regs[i]);
            exp_sum ^= regs[i];
        end
        n = exp_addr.size();

        start_i = 1'b1;
        first_i = ADDR_W'(f);
        last_i  = ADDR_W'(l);
        @(negedge clk);
        start_i = 1'b0;

        // One cycle after the accepted start the engine is fetching.
        check("fetch busy",   64'(busy_o), 1);
        check("fetch valid",  64'(dump_valid_o), 0);
        check("fetch raddr1", 64'(regRAddr1_o), 64'(f));
        check("fetch raddr2", 64'(regRAddr2_o), 64'((f < l) ? f + 1 : f));

        cyc = 0; got = 0; done_seen = 0; hold = 0;
        h_addr = '0; h_data = '0; h_last = 1'b0;
        while (!done_seen && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check("first word latency", 64'(dump_valid_o), 1);
            if (hold) begin
                check("hold valid", 64'(dump_valid_o), 1);
                check("hold addr",  64'(dump_addr_o), 64'(h_addr));
                check("hold data",  64'(dump_data_o), 64'(h_data));
                check("hold last",  64'(dump_last_o), 64'(h_last));
            end
            if (poke_start) begin
                start_i = (cyc == 3);
                first_i = ADDR_W'(2);
                last_i  = ADDR_W'(3);
            end
            if (done_o) begin
                done_seen = 1;
                break;
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 1);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            dump_ready_i = rdy;
            hold = dump_valid_o && !rdy;
            h_addr = dump_addr_o; h_data = dump_data_o; h_last = dump_last_o;
            if (dump_valid_o && rdy) begin
                if (exp_addr.size() == 0) begin
                    check("extra word", 64'(dump_addr_o), 64'hFFFF);
                end else begin
                    check("word addr", 64'(dump_addr_o), 64'(exp_addr[0]));
                    check("word data", 64'(dump_data_o), 64'(exp_data[0]));
                    check("word last", 64'(dump_last_o), 64'(exp_addr[0] == l));
                    void'(exp_addr.pop_front());
                    void'(exp_data.pop_front());
                    got++;
                end
            end
        end
        start_i = 1'b0;

        check("done seen",   64'(done_seen), 1);
        check("word count",  64'(got), 64'(n));
        check("done err",    64'(err_o), 0);
        check("done busy",   64'(busy_o), 0);
        check("checksum",    64'(checksum_o), 64'(exp_sum));
        if (mode == 0) check("cycles", 64'(cyc), 64'(n + (n + 1) / 2));
        dump_ready_i = 1'b0;
        @(negedge clk);
        check("done pulse",  64'(done_o), 0);
        check("idle busy",   64'(busy_o), 0);
    endtask

    initial begin
        logic [DATA_W-1:0] saved_sum;
        int                a;
        int                b;

        reset = 1'b1; start_i = 1'b0; first_i = '0; last_i = '0; dump_ready_i = 1'b0;
        for (int i = 0; i < 32; i++) regs[i] = '0;

        // Reset state.
        #2;
        check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post-reset raddr1", 64'(regRAddr1_o), 0);
        check("post-reset busy",   64'(busy_o), 0);

        // Full dump of ALU writeback results.
        regs[1] = 32'(5 + 3);
        regs[2] = 32'(10 - 4);
        regs[3] = 32'(7 & 3);
        regs[4] = 32'(5 | 2);
        regs[5] = 32'(5 ^ 2);
        run_dump(0, 31, 0, 0);
        check("full checksum const", 64'(checksum_o), 13);

        // Backpressure.
        run_dump(1, 4, 1, 0);
        check("bp checksum const", 64'(checksum_o), 10);

        // Odd and single ranges.
        run_dump(3, 7, 0, 0);
        run_dump(5, 5, 0, 0);

        // Rejected range.
        saved_sum = checksum_o;
        start_i = 1'b1; first_i = 5'd9; last_i = 5'd4;
        @(negedge clk);
        start_i = 1'b0;
        check("err pulse",  64'(err_o), 1);
        check("err done",   64'(done_o), 1);
        check("err busy",   64'(busy_o), 0);
        check("err valid",  64'(dump_valid_o), 0);
        @(negedge clk);
        check("err clear",  64'(err_o), 0);
        check("err dclear", 64'(done_o), 0);
        check("err busy2",  64'(busy_o), 0);
        check("err valid2", 64'(dump_valid_o), 0);
        check("err csum",   64'(checksum_o), 64'(saved_sum));

        // Abort mid-dump with random register contents.
        for (int i = 1; i < 32; i++) regs[i] = $urandom;
        start_i = 1'b1; first_i = 5'd0; last_i = 5'd31;
        @(negedge clk);
        start_i = 1'b0;
        dump_ready_i = 1'b1;
        repeat (5) @(negedge clk);
        check("abort pre valid", 64'(dump_valid_o), 1);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("abort");
        @(negedge clk);
        reset = 1'b0;
        dump_ready_i = 1'b0;
        @(negedge clk);
        check("abort raddr1", 64'(regRAddr1_o), 0);
        check("abort busy",   64'(busy_o), 0);

        // Fresh dump after abort, with a start pulsed while busy.
        run_dump(0, 31, 0, 1);

        // Randomized ranges and sink behaviour.
        for (int k = 0; k < 8; k++) begin
            for (int i = 1; i < 32; i++) regs[i] = $urandom;
            a = $urandom_range(0, 31);
            b = $urandom_range(a, 31);
            run_dump(a, b, (k % 3 == 0) ? 0 : 2, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
